led_pattern_gen: RTL

Multi-channel LED driver, a parametrised successor to the free-running single-LED blinker. Each of CHANNELS outputs is configured at run time through a single-cycle write port to one of four modes: OFF, ON, BLINK with a programmable half-period, or 8-bit PWM brightness. A shared prescaler sets the BLINK time base, and a global sync input phase-aligns all channels. It sits between the board-level control logic and the LED pins.

---
 rtl/led_pattern_gen.sv | 112 +++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: each channel is OFF, ON, BLINK (prescaled half-period)
// or 8-bit PWM, configured through a single-cycle write port; sync realigns all time bases.
module led_pattern_gen #(
  parameter int CHANNELS = 4,
  parameter int PRE_DIV  = 1024,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [7:0]          cfg_period,
  input  logic [7:0]          cfg_duty,
  input  logic                sync,
  output logic [CHANNELS-1:0] LED
);

  localparam int PRE_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;

  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [7:0]          pwm_cnt_q, pwm_cnt_d;
  logic [1:0]          mode_q   [CHANNELS];
  logic [1:0]          mode_d   [CHANNELS];
  logic [7:0]          period_q [CHANNELS];
  logic [7:0]          period_d [CHANNELS];
  logic [7:0]          duty_q   [CHANNELS];
  logic [7:0]          duty_d   [CHANNELS];
  logic [7:0]          bcnt_q   [CHANNELS];
  logic [7:0]          bcnt_d   [CHANNELS];
  logic [CHANNELS-1:0] bstate_q, bstate_d;
  logic [CHANNELS-1:0] led_q, led_d;

  logic tick;
  logic chan_ok;

  assign tick    = (pre_cnt_q == PRE_LAST);
  assign chan_ok = (32'(cfg_chan) < CHANNELS);
  assign LED     = led_q;

  always_comb begin
    pre_cnt_d = (sync || tick) ? '0 : pre_cnt_q + PRE_W'(1);
    pwm_cnt_d = sync ? 8'd0 : pwm_cnt_q + 8'd1;
    led_d     = '0;
    bstate_d  = bstate_q;
    for (int i = 0; i < CHANNELS; i++) begin
      mode_d[i]   = mode_q[i];
      period_d[i] = period_q[i];
      duty_d[i]   = duty_q[i];
      bcnt_d[i]   = bcnt_q[i];

      // Output is built from the current registers, so a new config shows one edge later.
      unique case (mode_q[i])
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_ON:    led_d[i] = 1'b1;
        MODE_BLINK: led_d[i] = bstate_q[i];
        default:    led_d[i] = (pwm_cnt_q < duty_q[i]);
      endcase

      // A write beats sync and tick for its own channel; sync beats tick.
      if (cfg_we && chan_ok && (cfg_chan == CH_W'(i))) begin
        mode_d[i]   = cfg_mode;
        period_d[i] = cfg_period;
        duty_d[i]   = cfg_duty;
        bcnt_d[i]   = 8'd0;
        bstate_d[i] = 1'b1;
      end else if (sync) begin
        bcnt_d[i]   = 8'd0;
        bstate_d[i] = 1'b1;
      end else if (tick) begin
        if (bcnt_q[i] == period_q[i]) begin
          bcnt_d[i]   = 8'd0;
          bstate_d[i] = ~bstate_q[i];
        end else begin
          bcnt_d[i]   = bcnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= 8'd0;
      bstate_q  <= '0;
      led_q     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= 8'd0;
        duty_q[i]   <= 8'd0;
        bcnt_q[i]   <= 8'd0;
      end
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      bstate_q  <= bstate_d;
      led_q     <= led_d;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= mode_d[i];
        period_q[i] <= period_d[i];
        duty_q[i]   <= duty_d[i];
        bcnt_q[i]   <= bcnt_d[i];
      end
    end
  end

endmodule
